// File: rtl/thermo_sample_ctrl.sv
// rtl/thermo_sample_ctrl.sv - periodic sampling and hysteresis controller
// Sequencer issues ld/st strobes, captures temp, and drives heat/cool demands.
module thermo_sample_ctrl #(
  parameter int unsigned PERIOD = 8,
  parameter int unsigned HYST   = 1,
  parameter int unsigned JUMP   = 6
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic [3:0] temp,
  input  logic [3:0] setpt,
  input  logic [1:0] mode,
  output logic       ld,
  output logic       st,
  output logic [3:0] temp_q,
  output logic       heat,
  output logic       cool,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_EVAL  = 3'd3,
    S_STORE = 3'd4
  } state_t;

  localparam logic [7:0] PERIOD_M1 = 8'(PERIOD - 1);
  localparam logic [4:0] HYST5     = 5'(HYST);
  localparam logic [4:0] JUMP5     = 5'(JUMP);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       ld_q, ld_d;
  logic       st_q, st_d;
  logic       busy_q, busy_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] prev_q, prev_d;
  logic       valid_q, valid_d;
  logic       heat_q, heat_d;
  logic       cool_q, cool_d;
  logic       fault_q, fault_d;
  logic       heat_n_q, heat_n_d;
  logic       cool_n_q, cool_n_d;
  logic       jump_q, jump_d;

  logic [4:0] t5, s5, p5, diff5;
  logic       heat_rule, cool_rule;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        // dropping en wins over period expiry
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == PERIOD_M1) begin
          state_d = S_LOAD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  state_d = S_STORE;
      S_STORE: begin
        state_d = en ? S_WAIT : S_IDLE;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Widen to 5 bits so setpt+HYST and temp+HYST never wrap.
  always_comb begin
    t5 = {1'b0, cap_q};
    s5 = {1'b0, setpt};
    p5 = {1'b0, prev_q};
    diff5 = (t5 >= p5) ? (t5 - p5) : (p5 - t5);

    heat_rule = heat_q;
    if ((t5 + HYST5) < s5)
      heat_rule = 1'b1;
    else if (t5 >= s5)
      heat_rule = 1'b0;

    cool_rule = cool_q;
    if (t5 > (s5 + HYST5))
      cool_rule = 1'b1;
    else if (t5 <= s5)
      cool_rule = 1'b0;
  end

  always_comb begin
    ld_d     = (state_q == S_LOAD);
    st_d     = (state_q == S_STORE);
    busy_d   = (state_q == S_LOAD) || (state_q == S_EVAL) || (state_q == S_STORE);
    cap_d    = cap_q;
    prev_d   = prev_q;
    valid_d  = valid_q;
    heat_d   = heat_q;
    cool_d   = cool_q;
    fault_d  = fault_q;
    heat_n_d = heat_n_q;
    cool_n_d = cool_n_q;
    jump_d   = jump_q;
    case (state_q)
      S_LOAD: begin
        cap_d  = temp;
        prev_d = cap_q;
      end
      S_EVAL: begin
        jump_d = valid_q && (diff5 >= JUMP5);
        case (mode)
          2'b01: begin
            heat_n_d = heat_rule;
            cool_n_d = 1'b0;
          end
          2'b10: begin
            heat_n_d = 1'b0;
            cool_n_d = cool_rule;
          end
          2'b11: begin
            heat_n_d = heat_rule;
            cool_n_d = cool_rule;
          end
          default: begin
            heat_n_d = 1'b0;
            cool_n_d = 1'b0;
          end
        endcase
      end
      S_STORE: begin
        // a fault, new or old, blanks both demands
        fault_d = fault_q | jump_q;
        heat_d  = fault_d ? 1'b0 : heat_n_q;
        cool_d  = fault_d ? 1'b0 : cool_n_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      busy_q   <= 1'b0;
      cap_q    <= 4'd0;
      prev_q   <= 4'd0;
      valid_q  <= 1'b0;
      heat_q   <= 1'b0;
      cool_q   <= 1'b0;
      fault_q  <= 1'b0;
      heat_n_q <= 1'b0;
      cool_n_q <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      ld_q     <= ld_d;
      st_q     <= st_d;
      busy_q   <= busy_d;
      cap_q    <= cap_d;
      prev_q   <= prev_d;
      valid_q  <= valid_d;
      heat_q   <= heat_d;
      cool_q   <= cool_d;
      fault_q  <= fault_d;
      heat_n_q <= heat_n_d;
      cool_n_q <= cool_n_d;
      jump_q   <= jump_d;
    end
  end

  assign ld     = ld_q;
  assign st     = st_q;
  assign busy   = busy_q;
  assign temp_q = cap_q;
  assign heat   = heat_q;
  assign cool   = cool_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_thermo_sample_ctrl.sv
// tb/tb_thermo_sample_ctrl.sv - directed self-checking bench for thermo_sample_ctrl
module tb_thermo_sample_ctrl;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic [3:0] temp;
  logic [3:0] setpt;
  logic [1:0] mode;
  logic       ld;
  logic       st;
  logic [3:0] temp_q;
  logic       heat;
  logic       cool;
  logic       busy;
  logic       fault;

  int checks;
  int failures;
  int nld;

  thermo_sample_ctrl #(.PERIOD(8), .HYST(1), .JUMP(6)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .en     (en),
    .temp   (temp),
    .setpt  (setpt),
    .mode   (mode),
    .ld     (ld),
    .st     (st),
    .temp_q (temp_q),
    .heat   (heat),
    .cool   (cool),
    .busy   (busy),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ld"}, ld, 1'b0);
    chk1({tag, "_st"}, st, 1'b0);
    chk4({tag, "_temp_q"}, temp_q, 4'd0);
    chk1({tag, "_heat"}, heat, 1'b0);
    chk1({tag, "_cool"}, cool, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_fault"}, fault, 1'b0);
  endtask

  task automatic wait_pulse(input bit want_st, input string tag);
    int  n;
    bit  found;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      if ((want_st ? st : ld) === 1'b1) found = 1'b1;
      n++;
    end
    if (!found) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=no_pulse expected=pulse", tag);
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic sample(input string tag, input logic [3:0] t,
                        input logic eh, input logic ec, input logic ef);
    temp = t;
    wait_pulse(1'b1, tag);
    chk1({tag, "_heat"}, heat, eh);
    chk1({tag, "_cool"}, cool, ec);
    chk1({tag, "_fault"}, fault, ef);
  endtask

  task automatic count_ld(input int cycles);
    nld = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (ld === 1'b1) nld++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr_n = 1'b0;
    en    = 1'b0;
    temp  = 4'd12;
    setpt = 4'd10;
    mode  = 2'b01;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk_all_zero("reset");

    // Latency: iteration i samples just after edge i; edge 0 sees en=1.
    clr_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i <= 21; i++) begin
      @(posedge clk);
      #1;
      chk1($sformatf("lat_ld_%0d", i), ld, (i == 9) || (i == 20));
      chk1($sformatf("lat_st_%0d", i), st, (i == 11));
      chk1($sformatf("lat_busy_%0d", i), busy,
           (i == 9) || (i == 10) || (i == 11) || (i == 20) || (i == 21));
      if (i == 9)  chk4("lat_cap1", temp_q, 4'd12);
      if (i == 11) begin
        chk1("lat_heat1", heat, 1'b0);
        temp = 4'd8;
      end
      if (i == 20) chk4("lat_cap2", temp_q, 4'd8);
    end
    // DUT is in STORE now; its pending heat=1 update must be lost.
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("store_reset");

    do_reset();
    en = 1'b1;
    mode = 2'b01;
    setpt = 4'd10;
    sample("heat_t8",  4'd8,  1'b1, 1'b0, 1'b0);
    sample("heat_t9",  4'd9,  1'b1, 1'b0, 1'b0);
    sample("heat_t10", 4'd10, 1'b0, 1'b0, 1'b0);
    sample("heat_t9b", 4'd9,  1'b0, 1'b0, 1'b0);
    sample("heat_t8b", 4'd8,  1'b1, 1'b0, 1'b0);

    mode = 2'b10;
    setpt = 4'd5;
    sample("cool_t7", 4'd7, 1'b0, 1'b1, 1'b0);
    sample("cool_t6", 4'd6, 1'b0, 1'b1, 1'b0);
    sample("cool_t5", 4'd5, 1'b0, 1'b0, 1'b0);

    do_reset();
    en = 1'b1;
    mode = 2'b10;
    setpt = 4'd15;
    sample("cool_nowrap_first", 4'd15, 1'b0, 1'b0, 1'b0);

    do_reset();
    en = 1'b1;
    mode = 2'b11;
    setpt = 4'd8;
    sample("auto_t6",  4'd6,  1'b1, 1'b0, 1'b0);
    sample("auto_t10", 4'd10, 1'b0, 1'b1, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    mode = 2'b00;
    @(posedge clk);
    #1;
    chk1("mode_off_hold_cool", cool, 1'b1);
    sample("mode_off_applied", 4'd10, 1'b0, 1'b0, 1'b0);

    do_reset();
    en = 1'b1;
    mode = 2'b11;
    setpt = 4'd8;
    sample("fault_t3",  4'd3,  1'b1, 1'b0, 1'b0);
    sample("fault_t12", 4'd12, 1'b0, 1'b0, 1'b1);
    sample("fault_t3b", 4'd3,  1'b0, 1'b0, 1'b1);
    do_reset();
    chk1("fault_cleared", fault, 1'b0);

    // WAIT abort: en drops when cnt has reached 4.
    en = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    count_ld(20);
    chk4("wait_abort_no_ld", 4'(nld), 4'd0);
    chk1("wait_abort_busy", busy, 1'b0);

    // EVAL drop: ld is visible while the DUT is in EVAL.
    en = 1'b1;
    temp = 4'd4;
    wait_pulse(1'b0, "eval_drop_ld");
    en = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk1("eval_drop_st", st, 1'b1);
    chk1("eval_drop_heat", heat, 1'b1);
    count_ld(20);
    chk4("eval_drop_no_ld", 4'(nld), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
